// File: rtl/speed_tick_gen.sv
// speed_tick_gen
// Turns the two raw speed switches into a debounced rate selection and a
// single-cycle clock-enable `tick` at the selected rate. Everything runs in
// the `clk` domain; downstream logic advances on `tick` instead of using a
// divided clock.
//
// Pipeline, per clock edge:
//   sw -> two-flop synchroniser -> per-bit debounce -> sw_db
//   next sw_db -> rate decode -> rate_sel / rate_chg
//   rate_sel -> divider counter -> tick
//
// A rate change restarts the divider from zero so the first tick at the new
// rate arrives a full new period after the change, never early.

module speed_tick_gen #(
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 26,
    parameter int P_SLOW     = 67108864,
    parameter int P_FAST     = 33554432,
    parameter int P_VFAST    = 16777216
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sw,
    output logic       tick,
    output logic [1:0] sw_db,
    output logic [1:0] rate_sel,
    output logic       rate_chg
);

    // Debounce counter is sized so that DEB_CYCLES-1 always fits.
    localparam int DEB_W = $clog2(DEB_CYCLES) + 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

    // Terminal counts are compared rather than periods, so a period of
    // exactly 2^CNT_W still fits in CNT_W bits.
    localparam logic [CNT_W-1:0] LAST_SLOW  = CNT_W'(P_SLOW - 1);
    localparam logic [CNT_W-1:0] LAST_FAST  = CNT_W'(P_FAST - 1);
    localparam logic [CNT_W-1:0] LAST_VFAST = CNT_W'(P_VFAST - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    localparam logic [1:0] RATE_SLOW  = 2'd0;
    localparam logic [1:0] RATE_FAST  = 2'd1;
    localparam logic [1:0] RATE_VFAST = 2'd2;

    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_sw_db;
    logic [1:0]       r_rate_sel;
    logic             r_rate_chg;
    logic [CNT_W-1:0] r_div_cnt;
    logic             r_tick;

    logic [1:0]       w_db_next;
    logic [1:0]       w_rate_next;
    logic             w_rate_change;
    logic [CNT_W-1:0] w_div_last;
    logic             w_div_wrap;

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // Each switch bit is debounced independently: a change is accepted only
    // after the synchronised value has differed from the accepted value for
    // DEB_CYCLES consecutive edges; any agreement in between restarts the run.
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        logic [DEB_W-1:0] r_deb_cnt;
        logic             w_differs;
        logic             w_settled;

        assign w_differs     = (r_sync2[gi] != r_sw_db[gi]);
        assign w_settled     = w_differs && (r_deb_cnt == DEB_LAST);
        assign w_db_next[gi] = w_settled ? r_sync2[gi] : r_sw_db[gi];

        // Count consecutive disagreeing edges; clear on agreement or acceptance.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_deb_cnt <= '0;
            end else if (!w_differs || w_settled) begin
                r_deb_cnt <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_ONE;
            end
        end
    end

    // Decode the rate from the value sw_db is about to take, so rate_sel
    // updates on the same edge as sw_db. sw[0] alone forces very fast.
    always_comb begin
        w_rate_next = RATE_SLOW;
        case (w_db_next)
            2'b00:   w_rate_next = RATE_SLOW;
            2'b10:   w_rate_next = RATE_FAST;
            default: w_rate_next = RATE_VFAST;
        endcase
    end

    assign w_rate_change = (w_rate_next != r_rate_sel);

    // Terminal count of the divider for the rate currently in force.
    always_comb begin
        w_div_last = LAST_SLOW;
        case (r_rate_sel)
            RATE_FAST:  w_div_last = LAST_FAST;
            RATE_VFAST: w_div_last = LAST_VFAST;
            default:    w_div_last = LAST_SLOW;
        endcase
    end

    assign w_div_wrap = (r_div_cnt == w_div_last);

    // Register the debounced switches, the active rate and its change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_db    <= 2'b00;
            r_rate_sel <= RATE_SLOW;
            r_rate_chg <= 1'b0;
        end else begin
            r_sw_db    <= w_db_next;
            r_rate_sel <= w_rate_next;
            r_rate_chg <= w_rate_change;
        end
    end

    // Divider: a rate change restarts the period and suppresses any tick that
    // would have fallen on the same edge; otherwise tick fires on wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (w_rate_change) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_tick    <= 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + CNT_ONE;
            r_tick    <= 1'b0;
        end
    end

    assign tick     = r_tick;
    assign sw_db    = r_sw_db;
    assign rate_sel = r_rate_sel;
    assign rate_chg = r_rate_chg;

endmodule

// File: tb/tb_speed_tick_gen.sv
// Testbench for speed_tick_gen with small parameters (debounce 4 cycles,
// periods 8/4/2). A behavioural model derives the expected outputs from the
// rules directly: a sliding window of synchronised samples for debouncing,
// and "edges since the last restart modulo period" for ticks.

module tb_speed_tick_gen;

    localparam int DEB     = 4;
    localparam int CW      = 4;
    localparam int PSLOW   = 8;
    localparam int PFAST   = 4;
    localparam int PVFAST  = 2;

    logic       clk;
    logic       rst;
    logic [1:0] sw;
    logic       tick;
    logic [1:0] swDb;
    logic [1:0] rateSel;
    logic       rateChg;

    int errors = 0;
    int checks = 0;

    speed_tick_gen #(
        .DEB_CYCLES(DEB),
        .CNT_W(CW),
        .P_SLOW(PSLOW),
        .P_FAST(PFAST),
        .P_VFAST(PVFAST)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .tick(tick),
        .sw_db(swDb),
        .rate_sel(rateSel),
        .rate_chg(rateChg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [1:0] rawQ[$];
    logic [1:0] sampQ[$];
    logic [1:0] mDb = 2'b00;
    logic [1:0] mRate = 2'd0;
    logic       mChg = 1'b0;
    logic       mTick = 1'b0;
    int         mSince = 0;
    logic [1:0] mS;
    logic [1:0] mNewDb;
    logic [1:0] mNewRate;
    bit         allDiff;

    function automatic logic [1:0] rateOf(input logic [1:0] d);
        if (d == 2'b00) return 2'd0;
        if (d == 2'b10) return 2'd1;
        return 2'd2;
    endfunction

    function automatic int periodOf(input logic [1:0] r);
        if (r == 2'd1) return PFAST;
        if (r == 2'd2) return PVFAST;
        return PSLOW;
    endfunction

    // The value the debouncer sees at an edge is the raw switch value of two
    // edges earlier; a reset loads zeros into that two-edge delay.
    always @(posedge clk) begin
        if (rst) begin
            rawQ   = {};
            rawQ.push_back(2'b00);
            rawQ.push_back(2'b00);
            sampQ  = {};
            mDb    = 2'b00;
            mRate  = 2'd0;
            mChg   = 1'b0;
            mTick  = 1'b0;
            mSince = 0;
        end else begin
            rawQ.push_back(sw);
            mS = rawQ[rawQ.size() - 3];
            if (rawQ.size() > 8) void'(rawQ.pop_front());
            sampQ.push_back(mS);
            if (sampQ.size() > DEB) void'(sampQ.pop_front());
            mNewDb = mDb;
            for (int b = 0; b < 2; b++) begin
                allDiff = (sampQ.size() == DEB);
                for (int k = 0; k < sampQ.size(); k++)
                    if (sampQ[k][b] == mDb[b]) allDiff = 0;
                if (allDiff) mNewDb[b] = ~mDb[b];
            end
            mNewRate = rateOf(mNewDb);
            mChg = (mNewRate != mRate);
            if (mChg) begin
                mSince = 0;
                mTick  = 1'b0;
            end else begin
                mSince = mSince + 1;
                mTick  = ((mSince % periodOf(mRate)) == 0);
            end
            mRate = mNewRate;
            mDb   = mNewDb;
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        stepClk();
        stepClk();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sw = 2'($urandom_range(0, 3));
            stepClk();
            checks++;
            if ({tick, rateChg, rateSel, swDb} !== 6'b0) begin
                errors++;
                $display("[TB] FAIL reset cyc=%0d got tick=%b chg=%b rate=%0d db=%b exp all zero",
                         i, tick, rateChg, rateSel, swDb);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_steady_slow();
        int nTicks = 0;
        int firstTick = -1;
        doReset();
        sw = 2'b00;
        for (int i = 1; i <= 40; i++) begin
            stepClk();
            checks++;
            if ({tick, rateChg, rateSel, swDb} !== {mTick, mChg, mRate, mDb}) begin
                errors++;
                $display("[TB] FAIL steady cyc=%0d got tick=%b chg=%b rate=%0d db=%b exp tick=%b chg=%b rate=%0d db=%b",
                         i, tick, rateChg, rateSel, swDb, mTick, mChg, mRate, mDb);
            end
            if (tick === 1'b1) begin
                nTicks++;
                if (firstTick < 0) firstTick = i;
            end
        end
        checks++;
        if (nTicks != 40 / PSLOW || firstTick != PSLOW) begin
            errors++;
            $display("[TB] FAIL steady_count got ticks=%0d first=%0d exp ticks=%0d first=%0d",
                     nTicks, firstTick, 40 / PSLOW, PSLOW);
        end
    endtask

    task automatic test_speed_change();
        sw = 2'b10;
        for (int i = 1; i <= 20; i++) begin
            stepClk();
            checks++;
            if ({tick, rateChg, rateSel, swDb} !== {mTick, mChg, mRate, mDb}) begin
                errors++;
                $display("[TB] FAIL speed_change cyc=%0d got tick=%b chg=%b rate=%0d db=%b exp tick=%b chg=%b rate=%0d db=%b",
                         i, tick, rateChg, rateSel, swDb, mTick, mChg, mRate, mDb);
            end
            if (i == 5 || i == 6 || i == 10) begin
                checks++;
                if ((i == 5 && swDb !== 2'b00) ||
                    (i == 6 && {swDb, rateSel, rateChg, tick} !== {2'b10, 2'd1, 1'b1, 1'b0}) ||
                    (i == 10 && {tick, rateChg} !== 2'b10)) begin
                    errors++;
                    $display("[TB] FAIL speed_change_edge cyc=%0d got db=%b rate=%0d chg=%b tick=%b",
                             i, swDb, rateSel, rateChg, tick);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] pat[$];
        int widths[5];
        widths = '{1, 2, 3, 0, 0};
        widths[3] = $urandom_range(1, DEB - 1);
        widths[4] = $urandom_range(1, DEB - 1);
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < widths[p]; k++) pat.push_back(p < 3 ? 2'b10 : 2'($urandom_range(1, 3)));
            pat.push_back(2'b00);
        end
        for (int k = 0; k < 20; k++) pat.push_back(2'b00);
        doReset();
        for (int i = 0; i < pat.size(); i++) begin
            sw = pat[i];
            stepClk();
            checks++;
            if ({tick, rateChg, rateSel, swDb} !== {mTick, mChg, mRate, mDb} ||
                swDb !== 2'b00 || rateChg !== 1'b0) begin
                errors++;
                $display("[TB] FAIL glitch cyc=%0d got tick=%b chg=%b rate=%0d db=%b exp tick=%b chg=0 rate=0 db=00",
                         i, tick, rateChg, rateSel, swDb, mTick);
            end
        end
    endtask

    task automatic test_same_rate();
        doReset();
        sw = 2'b01;
        for (int i = 1; i <= 30; i++) begin
            if (i == 15) sw = 2'b11;
            stepClk();
            checks++;
            if ({tick, rateChg, rateSel, swDb} !== {mTick, mChg, mRate, mDb}) begin
                errors++;
                $display("[TB] FAIL same_rate cyc=%0d got tick=%b chg=%b rate=%0d db=%b exp tick=%b chg=%b rate=%0d db=%b",
                         i, tick, rateChg, rateSel, swDb, mTick, mChg, mRate, mDb);
            end
            if (i == 6 || i >= 20) begin
                checks++;
                if ((i == 6 && {swDb, rateSel, rateChg} !== {2'b01, 2'd2, 1'b1}) ||
                    (i == 20 && {swDb, rateChg} !== {2'b11, 1'b0}) ||
                    (i > 20 && (rateChg !== 1'b0 || rateSel !== 2'd2 || tick !== 1'(i % 2 == 0)))) begin
                    errors++;
                    $display("[TB] FAIL same_rate_fixed cyc=%0d got db=%b rate=%0d chg=%b tick=%b",
                             i, swDb, rateSel, rateChg, tick);
                end
            end
        end
    endtask

    task automatic test_coincide();
        doReset();
        sw = 2'b00;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) sw = 2'b10;
            stepClk();
            checks++;
            if ({tick, rateChg, rateSel, swDb} !== {mTick, mChg, mRate, mDb}) begin
                errors++;
                $display("[TB] FAIL coincide cyc=%0d got tick=%b chg=%b rate=%0d db=%b exp tick=%b chg=%b rate=%0d db=%b",
                         i, tick, rateChg, rateSel, swDb, mTick, mChg, mRate, mDb);
            end
            if (i == PSLOW || i == PSLOW + PFAST) begin
                checks++;
                if ((i == PSLOW && {tick, rateChg} !== 2'b01) ||
                    (i == PSLOW + PFAST && tick !== 1'b1)) begin
                    errors++;
                    $display("[TB] FAIL coincide_edge cyc=%0d got tick=%b chg=%b", i, tick, rateChg);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        doReset();
        sw = 2'b10;
        for (int i = 1; i <= 11; i++) stepClk();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepClk();
            checks++;
            if ({tick, rateChg, rateSel, swDb} !== 6'b0) begin
                errors++;
                $display("[TB] FAIL reset_mid cyc=%0d got tick=%b chg=%b rate=%0d db=%b exp all zero",
                         i, tick, rateChg, rateSel, swDb);
            end
        end
        rst = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            stepClk();
            checks++;
            if ({tick, rateChg, rateSel, swDb} !== {mTick, mChg, mRate, mDb} ||
                (i == 6 && {swDb, rateChg} !== {2'b10, 1'b1}) ||
                (i == 10 && tick !== 1'b1)) begin
                errors++;
                $display("[TB] FAIL reset_release cyc=%0d got tick=%b chg=%b rate=%0d db=%b exp tick=%b chg=%b rate=%0d db=%b",
                         i, tick, rateChg, rateSel, swDb, mTick, mChg, mRate, mDb);
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        doReset();
        for (int i = 0; i < 400; i++) begin
            if (hold == 0) begin
                sw   = 2'($urandom_range(0, 3));
                hold = $urandom_range(1, 10);
            end
            hold--;
            rst = ($urandom_range(0, 99) < 2);
            stepClk();
            checks++;
            if ({tick, rateChg, rateSel, swDb} !== {mTick, mChg, mRate, mDb} || rateSel === 2'd3) begin
                errors++;
                $display("[TB] FAIL random cyc=%0d got tick=%b chg=%b rate=%0d db=%b exp tick=%b chg=%b rate=%0d db=%b",
                         i, tick, rateChg, rateSel, swDb, mTick, mChg, mRate, mDb);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sw  = 2'b00;
        test_reset();
        test_steady_slow();
        test_speed_change();
        test_glitch();
        test_same_rate();
        test_coincide();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
